// File: rtl/pf_clock_gen_multi.sv
// Multi-channel DDS clock-enable generator.
// Each channel adds its programmable increment into a phase accumulator; the accumulator carry
// becomes a one-cycle clock-enable pulse. A shared lock sequencer holds every channel idle for
// LOCK_CYCLES after reset or any increment write. Each channel then keeps its downstream reset
// asserted until it has produced RST_PULSES enable pulses.
module pf_clock_gen_multi #(
  parameter int unsigned      NUM_CH      = 4,
  parameter int unsigned      ACC_W       = 24,
  parameter int unsigned      LOCK_CYCLES = 256,
  parameter int unsigned      RST_PULSES  = 16,
  parameter logic [ACC_W-1:0] DEFAULT_INC = {2'b01, {(ACC_W - 2){1'b0}}},
  localparam int unsigned     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_we,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [ACC_W-1:0]  i_cfg_inc,
  input  logic [NUM_CH-1:0] i_ch_en,
  output logic [NUM_CH-1:0] o_ce,
  output logic [NUM_CH-1:0] o_rst,
  output logic              o_lock
);

  localparam int unsigned LCW = $clog2(LOCK_CYCLES);
  localparam int unsigned PCW = $clog2(RST_PULSES + 1);

  localparam logic [CH_W:0]    NumChV    = (CH_W + 1)'(NUM_CH);
  localparam logic [LCW-1:0]   LockLast  = LCW'(LOCK_CYCLES - 1);
  localparam logic [PCW-1:0]   PulseDone = PCW'(RST_PULSES);

  typedef enum logic [0:0] {StLocking, StLocked} state_e;

  state_e                       state_q;
  logic   [LCW-1:0]             lock_cnt_q;
  logic                         lock_q;
  logic   [NUM_CH-1:0][ACC_W-1:0] inc_q;
  logic   [NUM_CH-1:0][ACC_W-1:0] acc_q;
  logic   [NUM_CH-1:0][ACC_W:0]   sum;
  logic   [NUM_CH-1:0][PCW-1:0]   pcnt_q;
  logic   [NUM_CH-1:0]          ce_q;
  logic   [NUM_CH-1:0]          rst_q;
  logic                         cfg_hit;

  // Writes to a channel index that does not exist are dropped and must not relock.
  always_comb begin
    cfg_hit = i_cfg_we && ({1'b0, i_cfg_ch} < NumChV);
  end

  // One extra bit per channel so the carry out of the accumulator is the enable pulse.
  always_comb begin
    sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sum[c] = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
    end
  end

  // Lock sequencer and increment registers; any valid write restarts the lock count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StLocking;
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        inc_q[c] <= DEFAULT_INC;
      end
    end else if (cfg_hit) begin
      state_q    <= StLocking;
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (i_cfg_ch == CH_W'(c)) begin
          inc_q[c] <= i_cfg_inc;
        end
      end
    end else begin
      unique case (state_q)
        StLocking: begin
          if (lock_cnt_q == LockLast) begin
            state_q <= StLocked;
            lock_q  <= 1'b1;
          end else begin
            lock_cnt_q <= lock_cnt_q + LCW'(1);
          end
        end
        StLocked: begin
          lock_q <= 1'b1;
        end
        default: begin
          state_q <= StLocking;
          lock_q  <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel accumulator, enable pulse, pulse counter and downstream reset release.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q  <= '0;
      ce_q   <= '0;
      rst_q  <= '1;
      pcnt_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_hit || (state_q != StLocked) || !i_ch_en[c]) begin
          acc_q[c]  <= '0;
          ce_q[c]   <= 1'b0;
          rst_q[c]  <= 1'b1;
          pcnt_q[c] <= '0;
        end else begin
          acc_q[c] <= sum[c][ACC_W-1:0];
          ce_q[c]  <= sum[c][ACC_W];
          // Counter looks at the registered pulse, so it lags o_ce by one cycle.
          if (ce_q[c] && (pcnt_q[c] < PulseDone)) begin
            pcnt_q[c] <= pcnt_q[c] + PCW'(1);
          end
          if (pcnt_q[c] == PulseDone) begin
            rst_q[c] <= 1'b0;
          end
        end
      end
    end
  end

  assign o_ce   = ce_q;
  assign o_rst  = rst_q;
  assign o_lock = lock_q;

endmodule

// File: tb/tb_pf_clock_gen_multi.sv
// Directed bench for pf_clock_gen_multi (ACC_W=8, LOCK_CYCLES=8, RST_PULSES=2).
// Expected enable pulses use the closed form: pulse on cycle j after lock when
// floor(j*inc/256) steps; reset releases two cycles after the second pulse.
module tb_pf_clock_gen_multi;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_inc;
  logic [3:0] ch_en;
  logic [3:0] ce;
  logic [3:0] orst;
  logic       lock;

  logic       rst5;
  logic       we5;
  logic [2:0] ch5;
  logic [7:0] inc5;
  logic [4:0] en5;
  logic [4:0] ce5;
  logic [4:0] orst5;
  logic       lock5;

  int n_pass;
  int n_checks;
  int inc_m[4];

  pf_clock_gen_multi #(
    .NUM_CH(4), .ACC_W(8), .LOCK_CYCLES(8), .RST_PULSES(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch), .i_cfg_inc(cfg_inc),
    .i_ch_en(ch_en), .o_ce(ce), .o_rst(orst), .o_lock(lock)
  );

  pf_clock_gen_multi #(
    .NUM_CH(5), .ACC_W(8), .LOCK_CYCLES(8), .RST_PULSES(2)
  ) dut5 (
    .i_clk(clk), .i_rst(rst5), .i_cfg_we(we5), .i_cfg_ch(ch5), .i_cfg_inc(inc5),
    .i_ch_en(en5), .o_ce(ce5), .o_rst(orst5), .o_lock(lock5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic exp_ce(input int inc, input int j);
    if (j < 1) return 1'b0;
    return ((j * inc) / 256) != (((j - 1) * inc) / 256);
  endfunction

  function automatic logic exp_rst(input int inc, input int j);
    int n = 0;
    for (int k = 1; k <= j - 2; k++) if (exp_ce(inc, k)) n++;
    return n < 2;
  endfunction

  function automatic logic [3:0] ce_vec(input int j);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = exp_ce(inc_m[c], j);
    return v;
  endfunction

  function automatic logic [3:0] rst_vec(input int j);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = exp_rst(inc_m[c], j);
    return v;
  endfunction

  task automatic do_write(input int ch, input int inc);
    cfg_we  = 1'b1;
    cfg_ch  = 2'(ch);
    cfg_inc = 8'(inc);
    @(negedge clk);
    cfg_we = 1'b0;
    inc_m[ch] = inc;
  endtask

  task automatic test_reset;
    // A write while reset is high must be lost: ch1 keeps the default increment.
    rst = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_inc = 8'd0; ch_en = 4'hf;
    repeat (3) @(negedge clk);
    n_checks++; if (lock !== 1'b0) $display("FAIL reset_lock: got %b want 0", lock); else n_pass++;
    n_checks++; if (ce !== 4'h0) $display("FAIL reset_ce: got %b want 0000", ce); else n_pass++;
    n_checks++; if (orst !== 4'hf) $display("FAIL reset_rst: got %b want 1111", orst); else n_pass++;
    rst = 1'b0; cfg_we = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k >= 7) begin
        n_checks++;
        if (lock !== (k == 8)) $display("FAIL reset_lock_edge k=%0d: got %b want %b", k, lock, k == 8);
        else n_pass++;
      end
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (ce !== ce_vec(i)) $display("FAIL reset_ce_run i=%0d: got %b want %b", i, ce, ce_vec(i));
      else n_pass++;
      n_checks++;
      if (orst !== rst_vec(i)) $display("FAIL reset_rst_run i=%0d: got %b want %b", i, orst, rst_vec(i));
      else n_pass++;
    end
  endtask

  task automatic test_rate;
    int p1 = 0;
    do_write(1, 96);
    n_checks++; if (lock !== 1'b0) $display("FAIL rate_lock_drop: got %b want 0", lock); else n_pass++;
    n_checks++; if (ce !== 4'h0) $display("FAIL rate_ce_drop: got %b want 0000", ce); else n_pass++;
    n_checks++; if (orst !== 4'hf) $display("FAIL rate_rst_drop: got %b want 1111", orst); else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k >= 7) begin
        n_checks++;
        if (lock !== (k == 8)) $display("FAIL rate_lock k=%0d: got %b want %b", k, lock, k == 8);
        else n_pass++;
      end
    end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i > 8 && ce[1]) p1++;
      n_checks++;
      if (ce !== ce_vec(i)) $display("FAIL rate_ce i=%0d: got %b want %b", i, ce, ce_vec(i));
      else n_pass++;
      n_checks++;
      if (orst !== rst_vec(i)) $display("FAIL rate_rst i=%0d: got %b want %b", i, orst, rst_vec(i));
      else n_pass++;
    end
    n_checks++; if (p1 !== 3) $display("FAIL rate_density: got %0d want 3", p1); else n_pass++;
  endtask

  task automatic test_relock_locking;
    do_write(1, 96);
    repeat (5) @(negedge clk);
    // Lock counter is 5 here; an unchanged-value write must restart the full count.
    do_write(2, 64);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2 || k >= 7) begin
        n_checks++;
        if (lock !== (k == 8)) $display("FAIL relock_lock k=%0d: got %b want %b", k, lock, k == 8);
        else n_pass++;
      end
    end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (ce !== ce_vec(i)) $display("FAIL relock_ce i=%0d: got %b want %b", i, ce, ce_vec(i));
      else n_pass++;
    end
  endtask

  task automatic test_enable;
    logic [3:0] ece;
    logic [3:0] ers;
    // Continues the locked run of the previous task: i counts cycles since lock.
    for (int i = 17; i <= 40; i++) begin
      ch_en = (i <= 26) ? 4'b1011 : 4'b1111;
      @(negedge clk);
      ece = ce_vec(i);
      ers = rst_vec(i);
      ece[2] = (i <= 26) ? 1'b0 : exp_ce(64, i - 26);
      ers[2] = (i <= 26) ? 1'b1 : exp_rst(64, i - 26);
      n_checks++;
      if (ce !== ece) $display("FAIL enable_ce i=%0d: got %b want %b", i, ce, ece);
      else n_pass++;
      n_checks++;
      if (orst !== ers) $display("FAIL enable_rst i=%0d: got %b want %b", i, orst, ers);
      else n_pass++;
    end
  endtask

  task automatic test_inc_zero;
    do_write(3, 0);
    repeat (8) @(negedge clk);
    n_checks++; if (lock !== 1'b1) $display("FAIL zero_lock: got %b want 1", lock); else n_pass++;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_checks++;
      if (ce !== ce_vec(i)) $display("FAIL zero_ce i=%0d: got %b want %b", i, ce, ce_vec(i));
      else n_pass++;
      n_checks++;
      if (orst !== rst_vec(i)) $display("FAIL zero_rst i=%0d: got %b want %b", i, orst, rst_vec(i));
      else n_pass++;
    end
  endtask

  task automatic test_bad_channel;
    logic [4:0] ece;
    logic [4:0] ers;
    rst5 = 1'b1; we5 = 1'b0; ch5 = 3'd5; inc5 = 8'd0; en5 = 5'h1f;
    repeat (2) @(negedge clk);
    rst5 = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++; if (lock5 !== 1'b1) $display("FAIL bad_ch_lock: got %b want 1", lock5); else n_pass++;
    for (int i = 1; i <= 12; i++) begin
      we5 = (i == 5);
      @(negedge clk);
      we5 = 1'b0;
      for (int c = 0; c < 5; c++) begin
        ece[c] = exp_ce(64, i);
        ers[c] = exp_rst(64, i);
      end
      n_checks++;
      if (lock5 !== 1'b1) $display("FAIL bad_ch_relock i=%0d: got %b want 1", i, lock5);
      else n_pass++;
      n_checks++;
      if (ce5 !== ece) $display("FAIL bad_ch_ce i=%0d: got %b want %b", i, ce5, ece);
      else n_pass++;
      n_checks++;
      if (orst5 !== ers) $display("FAIL bad_ch_rst i=%0d: got %b want %b", i, orst5, ers);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int p0 = 0;
    int p1 = 0;
    do_write(0, 255);
    do_write(1, 1);
    repeat (8) @(negedge clk);
    n_checks++; if (lock !== 1'b1) $display("FAIL b2b_lock: got %b want 1", lock); else n_pass++;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (ce[0]) p0++;
      if (ce[1]) p1++;
      n_checks++;
      if (ce !== ce_vec(i)) $display("FAIL b2b_ce i=%0d: got %b want %b", i, ce, ce_vec(i));
      else n_pass++;
      n_checks++;
      if (orst !== rst_vec(i)) $display("FAIL b2b_rst i=%0d: got %b want %b", i, orst, rst_vec(i));
      else n_pass++;
    end
    n_checks++; if (p0 !== 255) $display("FAIL b2b_count255: got %0d want 255", p0); else n_pass++;
    n_checks++; if (p1 !== 1) $display("FAIL b2b_count1: got %0d want 1", p1); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_checks = 0;
    for (int c = 0; c < 4; c++) inc_m[c] = 64;
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_inc = 8'd0; ch_en = 4'hf;
    rst5 = 1'b1; we5 = 1'b0; ch5 = 3'd0; inc5 = 8'd0; en5 = 5'h1f;
    @(negedge clk);
    test_reset();
    test_rate();
    test_relock_locking();
    test_enable();
    test_inc_zero();
    test_bad_channel();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
